lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
CPU-side load/store initiator for the word-addressed data memory.
- Accepts one load/store request at a time from the execute/memory stage.
- Drives word-aligned read/write cycles with byte enables toward the data memory, then waits for that memory's acknowledge.
- Returns the sign- or zero-extended load data, plus an error flag, to the pipeline.
- Replaces direct combinational memory access so that memory latency and misaligned-access traps become possible.

Parameters:
TIMEOUT, 15, maximum cycles spent in ACCESS waiting for mem_ack before an error response (1..255).

Ports:
clk  in  1  core clock; all state changes on its rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  pipeline presents a request.
req_ready  out  1  high only in IDLE; the request is accepted when req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
rsp_valid  out  1  single-cycle response strobe.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned, illegal funct3, or timeout; valid with rsp_valid.
busy  out  1  high from acceptance until the rsp_valid cycle inclusive; used as pipeline stall.
mem_read  out  1  read strobe to data memory.
mem_write  out  1  write strobe to data memory.
mem_addr  out  32  {req_addr[31:2], 2'b00}.
mem_wdata  out  32  lane-replicated store data.
mem_be  out  4  byte enables; bit i selects byte lane [8i+7:8i].
mem_rdata  in  32  read data, sampled in the mem_ack cycle.
mem_ack  in  1  memory completed the access this cycle.

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_be=0; timer=0.
- States:
  - IDLE: on accept, latch we/funct3/addr/wdata.
    - If the request is illegal, go to DONE with err=1.
    - Otherwise go to ACCESS and clear the timer.
  - ACCESS:
    - Drive mem_read = ~we and mem_write = we, plus mem_addr, mem_wdata and mem_be; all are registered and stable for the whole state.
    - If mem_ack: capture and extend the data, then go to DONE.
    - Else if timer == TIMEOUT-1: go to DONE with err=1.
    - Else timer++.
  - DONE: rsp_valid=1 for exactly one cycle, then return to IDLE. Strobes are 0.
- Illegal conditions:
  - funct3 in {3,6,7}.
  - Store funct3 > 2.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - Illegal requests never assert mem_read or mem_write.
- Latency, accept edge to rsp_valid:
  - 2 cycles when mem_ack arrives in the first ACCESS cycle; +1 per wait cycle.
  - Illegal request: 1 cycle.
  - Throughput: one request per 3 cycles minimum (IDLE–ACCESS–DONE).
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
  - Loads also drive the mem_be pattern (informational).
- Store data replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extraction:
  - Select the byte/half lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_ack outside ACCESS is ignored.
- req_valid while busy is ignored; req_ready=0 there.
- Reset mid-operation drops the strobes immediately and produces no response. The in-flight request is lost, and the pipeline must reissue it.
- A late mem_ack arriving in the DONE cycle after a timeout is ignored.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - the state enum (IDLE=0, ACCESS=1, DONE=2);
  - the default timeout constant.
- One combinational sub-module, lsu_align: from funct3, addr[1:0], wdata and rdata it produces mem_be, mem_wdata, the extended load data and the illegal flag. It is shared with the future instruction-fetch misalignment check.

Test Plan:
1. Memory word 0x104 = 5; LW addr 0x104, ack on the first ACCESS cycle -> mem_read=1, mem_be=4'hF, mem_addr=0x104; rsp_valid 2 cycles after accept; rsp_rdata=5; rsp_err=0.
2. SB addr 0x101, wdata 0x123456AB -> mem_write=1, mem_addr=0x100, mem_be=4'b0010, mem_wdata=0xABABABAB; rsp_rdata=0.
3. mem_rdata=0x8001_80FF at addr 0x100 cases:
   - LB 0x100 -> 0xFFFFFFFF.
   - LBU 0x100 -> 0x000000FF.
   - LH 0x102 -> 0xFFFF8001.
   - LHU 0x102 -> 0x00008001.
4. Illegal requests: LW 0x102, SH 0x103, funct3=3 -> rsp_err=1 one cycle after accept; mem_read and mem_write stay 0 throughout.
5. mem_ack held low -> exactly TIMEOUT (15) ACCESS cycles, then rsp_err=1; a mem_ack in the following DONE cycle causes no second rsp_valid.
6. Assert rst_n=0 mid-ACCESS (3-cycle wait) -> mem_read falls without a clock edge, no rsp_valid; after release a new LW 0x100 returns 4.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory side: RV32I width codes,
// the load/store controller state encoding and the default ack timeout.
package cpu_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only while the controller is idle. The response is a
// one-cycle rsp_valid strobe with rsp_rdata/rsp_err valid in that cycle.
// The memory completes an access by raising mem_ack for one cycle while a
// strobe is held; mem_rdata is sampled in that same cycle.
// master: the load/store controller. slave: pipeline plus data memory.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mem_read, mem_write, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mem_read, mem_write, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic: byte enables, store-data replication,
// load-data extraction/extension and the illegal-access flag.
module lsu_align
    import cpu_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        illegal
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Pick the addressed byte and halfword lanes out of the memory word.
    always_comb begin
        rbyte = 8'h00;
        case (addr_lo)
            2'd0: rbyte = rdata[7:0];
            2'd1: rbyte = rdata[15:8];
            2'd2: rbyte = rdata[23:16];
            2'd3: rbyte = rdata[31:24];
            default: rbyte = 8'h00;
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Width decode: enables, replication, extension and legality.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        illegal   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
                illegal   = addr_lo[0];
            end
            F3_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
                illegal   = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: takes one pipeline request at a time, runs a
// word-aligned read or write cycle on the data memory and returns the
// extended load data with an error flag (misaligned, illegal width, timeout).
module lsu_mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.master bus,
    output lsu_state_t     dbg_state
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  timer_q;
    logic        mem_read_q, mem_write_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        timed_out;
    logic [2:0]  al_f3;
    logic        al_we;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_illegal;

    // In IDLE the lane logic judges the incoming request; afterwards it
    // works on the latched request so the load data can be extended.
    always_comb begin
        al_f3     = (state_q == IDLE) ? bus.req_funct3    : f3_q;
        al_we     = (state_q == IDLE) ? bus.req_we        : we_q;
        al_lo     = (state_q == IDLE) ? bus.req_addr[1:0] : addr_lo_q;
        accept    = bus.req_valid && (state_q == IDLE);
        timed_out = (state_q == ACCESS) && !bus.mem_ack && (timer_q == 8'(TIMEOUT - 1));
    end

    lsu_align u_align (
        .funct3    (al_f3),
        .we        (al_we),
        .addr_lo   (al_lo),
        .wdata     (bus.req_wdata),
        .rdata     (bus.mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .illegal   (al_illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = al_illegal ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack || timed_out) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, memory-bus registers, ack timer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_lo_q   <= 2'd0;
            timer_q     <= 8'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= bus.req_we;
                        f3_q        <= bus.req_funct3;
                        addr_lo_q   <= bus.req_addr[1:0];
                        timer_q     <= 8'd0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= al_illegal;
                        // Illegal requests never reach the memory bus.
                        if (!al_illegal) begin
                            mem_read_q  <= ~bus.req_we;
                            mem_write_q <= bus.req_we;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_q <= al_wdata;
                            mem_be_q    <= al_be;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0 : al_rdata;
                        rsp_err_q   <= 1'b0;
                    end else if (timed_out) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                DONE: begin
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; response and stall flags decode straight from state.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.rsp_valid = (state_q == DONE);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
        bus.mem_read  = mem_read_q;
        bus.mem_write = mem_write_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.mem_be    = mem_be_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus randomized requests
// checked against a behavioural model of widths, alignment and lanes.
module tb_lsu_mem_ctrl;
    import cpu_mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    lsu_state_t dbg_state;
    int         n_vec = 0;
    int         n_err = 0;
    logic [31:0] mem_model [256];

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural reference: size from width code, alignment by modulo,
    // lane placement and extension by plain arithmetic.
    function automatic void ref_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] word,
                                    output logic err, output logic [3:0] be,
                                    output logic [31:0] mwd, output logic [31:0] rd);
        int     size;
        int     off;
        longint v;
        off  = int'(addr % 4);
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        err  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 > 2) || (int'(addr) % size != 0);
        be = 4'h0; mwd = 32'h0; rd = 32'h0;
        if (!err) begin
            be = 4'(((1 << size) - 1) << off);
            if (size == 1)      mwd = (wdata & 32'hFF) * 32'h01010101;
            else if (size == 2) mwd = (wdata & 32'hFFFF) * 32'h00010001;
            else                mwd = wdata;
            if (!we) begin
                v = longint'(word >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
                if (f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                rd = 32'(v);
            end
        end
    endfunction

    // Driver plus memory responder for one request. Observations are returned
    // to the calling test, which does its own comparisons.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wait_n, input bit ack_en,
                           input bit late_ack, input bit garbage, input bit idle_ack,
                           output int lat, output int acc_cyc, output logic [31:0] rdata,
                           output logic err, output logic [31:0] m_addr, output logic [3:0] m_be,
                           output logic [31:0] m_wdata, output logic saw_rd, output logic saw_wr,
                           output int glitches, output bit got_rsp, output bit extra_rsp);
        lat = 0; acc_cyc = 0; rdata = 32'h0; err = 1'b0; m_addr = 32'h0; m_be = 4'h0;
        m_wdata = 32'h0; saw_rd = 1'b0; saw_wr = 1'b0; glitches = 0; got_rsp = 1'b0; extra_rsp = 1'b0;
        @(negedge clk);
        if (!bus.req_ready) glitches++;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.mem_ack = idle_ack;
        @(posedge clk);
        #1;
        if (garbage) begin
            bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
        while (!got_rsp && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!bus.busy || bus.req_ready) glitches++;
            if (bus.mem_read || bus.mem_write) begin
                acc_cyc++;
                if (acc_cyc == 1) begin
                    m_addr = bus.mem_addr; m_be = bus.mem_be; m_wdata = bus.mem_wdata;
                end else if (m_addr !== bus.mem_addr || m_be !== bus.mem_be || m_wdata !== bus.mem_wdata) begin
                    glitches++;
                end
                if (bus.mem_read && bus.mem_write) glitches++;
                saw_rd |= bus.mem_read;
                saw_wr |= bus.mem_write;
                if (ack_en && acc_cyc == wait_n + 1) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = mem_model[addr[9:2]];
                end else begin
                    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (bus.rsp_valid) begin
                got_rsp = 1'b1; rdata = bus.rsp_rdata; err = bus.rsp_err;
                bus.req_valid = 1'b0; bus.mem_ack = late_ack;
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        extra_rsp = bus.rsp_valid || bus.busy;
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
        n_vec++; if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.mem_read, bus.mem_write} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 00000", {bus.rsp_valid, bus.rsp_err, bus.busy, bus.mem_read, bus.mem_write}); end
        n_vec++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata); end
        n_vec++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
            n_err++; $display("FAIL reset_membus got %h/%h/%h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        int lat, acc, gl; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        mem_model[8'h41] = 32'd5;
        run_txn(1'b0, F3_W, 32'h104, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0,
                lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
        n_vec++; if (!got || lat != 2) begin n_err++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_vec++; if (rd !== 32'd5 || er !== 1'b0) begin n_err++; $display("FAIL lw_data got %h/%b want 5/0", rd, er); end
        n_vec++; if ({sr, sw} !== 2'b10 || ma !== 32'h104 || mb !== 4'hF) begin
            n_err++; $display("FAIL lw_bus got rd%b wr%b %h %h want 1 0 104 f", sr, sw, ma, mb); end
        n_vec++; if (gl != 0 || ex) begin n_err++; $display("FAIL lw_protocol got %0d glitches extra %0d want 0", gl, ex); end
    endtask

    task automatic test_store_byte();
        int lat, acc, gl; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        run_txn(1'b1, F3_B, 32'h101, 32'h123456AB, 1, 1'b1, 1'b0, 1'b0, 1'b0,
                lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
        n_vec++; if ({sr, sw} !== 2'b01 || ma !== 32'h100 || mb !== 4'b0010) begin
            n_err++; $display("FAIL sb_bus got rd%b wr%b %h %b want 0 1 100 0010", sr, sw, ma, mb); end
        n_vec++; if (mw !== 32'hABABABAB) begin n_err++; $display("FAIL sb_wdata got %h want abababab", mw); end
        n_vec++; if (!got || lat != 3 || rd !== 32'h0 || er !== 1'b0) begin
            n_err++; $display("FAIL sb_rsp got lat%0d %h/%b want lat3 0/0", lat, rd, er); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] ads [4] = '{32'h100, 32'h100, 32'h102, 32'h102};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8001, 32'h00008001};
        int lat, acc, gl; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        mem_model[8'h40] = 32'h800180FF;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, f3s[i], ads[i], 32'h0, i, 1'b1, 1'b0, 1'b0, 1'b1,
                    lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
            n_vec++; if (!got || rd !== exp[i] || er !== 1'b0) begin
                n_err++; $display("FAIL load_ext[%0d] got %h/%b want %h/0", i, rd, er, exp[i]); end
        end
    endtask

    task automatic test_illegal();
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{F3_W, F3_H, 3'd3};
        logic [31:0] ads [3] = '{32'h102, 32'h103, 32'h100};
        int lat, acc, gl; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        for (int i = 0; i < 3; i++) begin
            run_txn(wes[i], f3s[i], ads[i], 32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b0, 1'b1,
                    lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
            n_vec++; if (!got || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
                n_err++; $display("FAIL illegal[%0d] got lat%0d err%b %h want lat1 err1 0", i, lat, er, rd); end
            n_vec++; if (acc != 0 || sr || sw || gl != 0 || ex) begin
                n_err++; $display("FAIL illegal_bus[%0d] got %0d strobe cycles want 0", i, acc); end
        end
    endtask

    task automatic test_timeout();
        int lat, acc, gl; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        run_txn(1'b0, F3_W, 32'h100, 32'h0, 0, 1'b0, 1'b1, 1'b1, 1'b0,
                lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
        n_vec++; if (acc != 15) begin n_err++; $display("FAIL timeout_cycles got %0d want 15", acc); end
        n_vec++; if (!got || lat != 16 || er !== 1'b1 || rd !== 32'h0) begin
            n_err++; $display("FAIL timeout_rsp got lat%0d err%b %h want lat16 err1 0", lat, er, rd); end
        n_vec++; if (ex || gl != 0) begin n_err++; $display("FAIL timeout_late_ack got extra %0d glitches %0d want 0", ex, gl); end
    endtask

    task automatic test_reset_mid();
        int lat, acc, gl, rsp_seen; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        rsp_seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h100;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got mem_read %b want 1", bus.mem_read); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_drop got mem_read %b busy %b want 0 0", bus.mem_read, bus.busy); end
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
        end
        n_vec++; if (rsp_seen != 0) begin n_err++; $display("FAIL rstmid_norsp got %0d responses want 0", rsp_seen); end
        mem_model[8'h40] = 32'd4;
        run_txn(1'b0, F3_W, 32'h100, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0,
                lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
        n_vec++; if (!got || rd !== 32'd4 || er !== 1'b0) begin n_err++; $display("FAIL rstmid_reissue got %h/%b want 4/0", rd, er); end
    endtask

    task automatic test_random();
        int lat, acc, gl, wt; logic [31:0] rd, ma, mw; logic er, sr, sw; logic [3:0] mb; bit got, ex;
        logic we; logic [2:0] f3; logic [31:0] addr, wdata, word;
        logic e_err; logic [3:0] e_be; logic [31:0] e_mwd, e_rd;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom); f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023)); wdata = $urandom; wt = $urandom_range(0, 4);
            word = mem_model[addr[9:2]];
            ref_txn(we, f3, addr, wdata, word, e_err, e_be, e_mwd, e_rd);
            run_txn(we, f3, addr, wdata, wt, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                    lat, acc, rd, er, ma, mb, mw, sr, sw, gl, got, ex);
            n_vec++; if (!got || er !== e_err || rd !== e_rd) begin
                n_err++; $display("FAIL rand_rsp[%0d] we%b f3=%0d a=%h got %h/%b want %h/%b", i, we, f3, addr, rd, er, e_rd, e_err); end
            n_vec++; if (lat != (e_err ? 1 : 2 + wt) || gl != 0 || ex) begin
                n_err++; $display("FAIL rand_timing[%0d] got lat%0d glitches%0d extra%0d want lat%0d", i, lat, gl, ex, e_err ? 1 : 2 + wt); end
            if (e_err) begin
                n_vec++; if (sr || sw) begin n_err++; $display("FAIL rand_illegal_bus[%0d] got rd%b wr%b want 0 0", i, sr, sw); end
            end else begin
                n_vec++; if (sr !== ~we || sw !== we || ma !== {addr[31:2], 2'b00} || mb !== e_be || mw !== e_mwd) begin
                    n_err++; $display("FAIL rand_bus[%0d] got rd%b wr%b %h %b %h want %b %b %h %b %h", i, sr, sw, ma, mb, mw,
                                      ~we, we, {addr[31:2], 2'b00}, e_be, e_mwd); end
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (e_be[b]) word[8*b +: 8] = e_mwd[8*b +: 8];
                    mem_model[addr[9:2]] = word;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_ext();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
